// File: rtl/nes_tb_pkg.sv
// Shared definitions for the controller input sequencer: button masks,
// script entry field layout and the playback state encoding.
package nes_tb_pkg;

    localparam logic [7:0] BTN_A      = 8'h01;
    localparam logic [7:0] BTN_B      = 8'h02;
    localparam logic [7:0] BTN_SELECT = 8'h04;
    localparam logic [7:0] BTN_START  = 8'h08;
    localparam logic [7:0] BTN_UP     = 8'h10;
    localparam logic [7:0] BTN_DOWN   = 8'h20;
    localparam logic [7:0] BTN_LEFT   = 8'h40;
    localparam logic [7:0] BTN_RIGHT  = 8'h80;

    localparam int ENTRY_W   = 24;
    localparam int FIELD_W   = 8;
    localparam int BTNS0_LSB = 0;
    localparam int BTNS1_LSB = 8;
    localparam int DUR_LSB   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/input_sequencer_seq_ram.sv
// Script storage: simple dual-port memory, one write port and one
// registered (one-cycle latency) read port. Contents are never reset.
module seq_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/input_sequencer.sv
// Replays a scripted sequence of controller button states, one entry per
// run of frames, advancing on rising edges of the PPU vblank signal.
module input_sequencer
    import nes_tb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter bit LOOP  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [23:0]              prog_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     vblank,
    output logic [7:0]               btns0,
    output logic [7:0]               btns1,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] entry_idx,
    output logic [15:0]              frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    seq_state_t  state;
    logic        vblank_q;
    logic [7:0]  remaining;
    logic [23:0] rd_data;
    logic [7:0]  dur;
    logic        frame_edge;
    logic        wr_en;

    assign frame_edge = vblank & ~vblank_q;
    assign wr_en      = prog_we & ((state == ST_IDLE) | (state == ST_DONE));
    assign dur        = rd_data[DUR_LSB +: FIELD_W];

    seq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (entry_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            vblank_q  <= 1'b1;
            btns0     <= 8'h00;
            btns1     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            entry_idx <= '0;
            frame_cnt <= 16'h0000;
            remaining <= 8'h00;
        end else begin
            vblank_q <= vblank;
            if (abort) begin
                state     <= ST_IDLE;
                btns0     <= 8'h00;
                btns1     <= 8'h00;
                busy      <= 1'b0;
                done      <= 1'b0;
                entry_idx <= '0;
                remaining <= 8'h00;
            end else begin
                if (frame_edge && busy && frame_cnt != 16'hFFFF) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state     <= ST_FETCH;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            entry_idx <= '0;
                            frame_cnt <= 16'h0000;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (dur == 8'h00) begin
                            // A terminator at entry 0 ends even a looping script.
                            if (LOOP && entry_idx != '0) begin
                                entry_idx <= '0;
                                state     <= ST_FETCH;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                btns0 <= 8'h00;
                                btns1 <= 8'h00;
                            end
                        end else if (frame_edge) begin
                            // The arming edge already counts as the entry's first frame.
                            btns0     <= rd_data[BTNS0_LSB +: FIELD_W];
                            btns1     <= rd_data[BTNS1_LSB +: FIELD_W];
                            remaining <= dur - 8'd1;
                            state     <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (remaining == 8'h00) begin
                            if (entry_idx != LAST_IDX) begin
                                entry_idx <= entry_idx + AW'(1);
                                state     <= ST_FETCH;
                            end else if (LOOP) begin
                                entry_idx <= '0;
                                state     <= ST_FETCH;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                btns0 <= 8'h00;
                                btns1 <= 8'h00;
                            end
                        end else if (frame_edge) begin
                            remaining <= remaining - 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: a one-shot and a looping instance share all
// inputs; expected button streams are expanded from the script table.
module tb_input_sequencer;
    import nes_tb_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [23:0]   prog_data;
    logic          start;
    logic          abort;
    logic          vblank;

    logic [7:0]    a_btns0, a_btns1, b_btns0, b_btns1;
    logic          a_busy, a_done, b_busy, b_done;
    logic [AW-1:0] a_idx, b_idx;
    logic [15:0]   a_fcnt, b_fcnt;

    int checks = 0;
    int errors = 0;
    logic [23:0] script [DEPTH];

    always #5 clk = ~clk;

    input_sequencer #(.DEPTH(DEPTH), .LOOP(1'b0)) dut_once (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .abort(abort), .vblank(vblank),
        .btns0(a_btns0), .btns1(a_btns1), .busy(a_busy), .done(a_done),
        .entry_idx(a_idx), .frame_cnt(a_fcnt)
    );

    input_sequencer #(.DEPTH(DEPTH), .LOOP(1'b1)) dut_loop (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .abort(abort), .vblank(vblank),
        .btns0(b_btns0), .btns1(b_btns1), .busy(b_busy), .done(b_done),
        .entry_idx(b_idx), .frame_cnt(b_fcnt)
    );

    task automatic prog(input int addr, input logic [23:0] d, input bit model);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = AW'(addr); prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        if (model) script[addr] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk); vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Expected stream: each entry's button pair repeated dur times, ending at
    // the first dur=0 entry or after the last memory entry.
    task automatic run_script(input string name, input int extra, input bit poke);
        logic [15:0] exp_q[$];
        int last_idx;
        int len;
        exp_q = {};
        last_idx = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (script[i][23:16] == 8'h00) begin
                last_idx = i;
                break;
            end
            repeat (int'(script[i][23:16])) exp_q.push_back(script[i][15:0]);
        end
        len = exp_q.size();
        pulse_start();
        for (int k = 1; k <= len + extra; k++) begin
            frame();
            checks++;
            if (k < len) begin
                if ({a_btns1, a_btns0} !== exp_q[k-1] || a_busy !== 1'b1 ||
                    a_done !== 1'b0 || a_fcnt !== 16'(k)) begin
                    errors++;
                    $display("FAIL %s frame %0d: btns=%h busy=%b done=%b fcnt=%0d, want btns=%h busy=1 done=0 fcnt=%0d",
                             name, k, {a_btns1, a_btns0}, a_busy, a_done, a_fcnt, exp_q[k-1], k);
                end
            end else begin
                if (a_done !== 1'b1 || a_busy !== 1'b0 || {a_btns1, a_btns0} !== 16'h0000 ||
                    a_fcnt !== 16'(len) || a_idx !== AW'(last_idx)) begin
                    errors++;
                    $display("FAIL %s end frame %0d: done=%b busy=%b btns=%h fcnt=%0d idx=%0d, want done=1 busy=0 btns=0000 fcnt=%0d idx=%0d",
                             name, k, a_done, a_busy, {a_btns1, a_btns0}, a_fcnt, a_idx, len, last_idx);
                end
            end
            // Write and restart while busy must both be ignored.
            if (poke && k == 1 && len >= 2) begin
                prog(1, 24'h01FFEE, 1'b0);
                pulse_start();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vblank = 1'b1; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_btns1, a_btns0, b_btns1, b_btns0} !== 32'h0 || a_busy !== 1'b0 || a_done !== 1'b0 ||
            b_busy !== 1'b0 || b_done !== 1'b0 || a_idx !== '0 || b_idx !== '0 ||
            a_fcnt !== 16'h0 || b_fcnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: a btns=%h busy=%b done=%b idx=%0d fcnt=%0d, want all zero",
                     {a_btns1, a_btns0}, a_busy, a_done, a_idx, a_fcnt);
        end
        // vblank has been high since before reset release: not an edge.
        prog(0, {8'd2, 8'h00, 8'h5A}, 1'b1);
        prog(1, 24'h000000, 1'b1);
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (a_fcnt !== 16'h0 || a_btns0 !== 8'h00 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL vblank_high_at_reset: fcnt=%0d btns0=%h busy=%b, want fcnt=0 btns0=00 busy=1",
                     a_fcnt, a_btns0, a_busy);
        end
        vblank = 1'b0;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (a_fcnt !== 16'h1 || a_btns0 !== 8'h5A) begin
            errors++;
            $display("FAIL first_real_edge: fcnt=%0d btns0=%h, want fcnt=1 btns0=5a", a_fcnt, a_btns0);
        end
        vblank = 1'b0;
        pulse_abort();
    endtask

    task automatic test_basic_script();
        pulse_abort();
        prog(0, {8'd5, 8'h00, BTN_START}, 1'b1);
        prog(1, {8'd3, 8'h00, BTN_A}, 1'b1);
        prog(2, {8'd0, 8'h12, 8'h34}, 1'b1);
        run_script("basic", 4, 1'b0);
    endtask

    task automatic test_random_scripts();
        for (int it = 0; it < 4; it++) begin
            int n;
            pulse_abort();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++)
                prog(i, {8'($urandom_range(1, 4)), 16'($urandom)}, 1'b1);
            prog(n, {8'h00, 16'($urandom)}, 1'b1);
            run_script("random", 2, it[0]);
        end
    endtask

    task automatic test_write_while_busy();
        pulse_abort();
        prog(0, {8'd3, 8'h00, 8'h11}, 1'b1);
        prog(1, {8'd2, 8'h33, 8'h22}, 1'b1);
        prog(2, 24'h000000, 1'b1);
        run_script("write_busy", 1, 1'b1);
    endtask

    task automatic test_abort();
        pulse_abort();
        prog(0, {8'd4, 8'hAA, 8'h55}, 1'b1);
        prog(1, 24'h000000, 1'b1);
        pulse_start();
        frame();
        frame();
        @(negedge clk);
        vblank = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || {a_btns1, a_btns0} !== 16'h0 || a_idx !== '0 ||
            b_busy !== 1'b0 || {b_btns1, b_btns0} !== 16'h0) begin
            errors++;
            $display("FAIL abort_with_edge: busy=%b done=%b btns=%h idx=%0d, want busy=0 done=0 btns=0000 idx=0",
                     a_busy, a_done, {a_btns1, a_btns0}, a_idx);
        end
        vblank = 1'b0;
        frame();
        frame();
        checks++;
        if (a_busy !== 1'b0 || {a_btns1, a_btns0} !== 16'h0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy=%b done=%b btns=%h, want idle with btns=0000",
                     a_busy, a_done, {a_btns1, a_btns0});
        end
    endtask

    task automatic test_loop();
        pulse_abort();
        prog(0, {8'd2, 8'h00, BTN_RIGHT}, 1'b1);
        prog(1, 24'h000000, 1'b1);
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); vblank = 1'b1;
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                if (c == 2) vblank = 1'b0;
                checks++;
                if (b_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL loop_busy frame %0d cycle %0d: busy=%b, want 1", k, c, b_busy);
                end
            end
            checks++;
            if (b_btns0 !== 8'h80 || b_btns1 !== 8'h00 || b_idx !== '0 || b_done !== 1'b0) begin
                errors++;
                $display("FAIL loop frame %0d: btns=%h idx=%0d done=%b, want btns=0080 idx=0 done=0",
                         k, {b_btns1, b_btns0}, b_idx, b_done);
            end
        end
        pulse_abort();
    endtask

    task automatic test_full_depth();
        pulse_abort();
        for (int i = 0; i < DEPTH; i++)
            prog(i, {8'd1, 8'(i), 8'(i + 1)}, 1'b1);
        run_script("full_depth", 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_script();
        test_random_scripts();
        test_write_while_busy();
        test_abort();
        test_loop();
        test_full_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
